addr_map_lookup_ctrl: RTL

Runtime-programmable address-map controller. It holds a double-buffered table of `addr_map_rule_pkg::addr_map_rule_t` entries: a shadow bank written by software configuration and an active bank used for lookups. It decodes lookup addresses through a registered valid/ready pipeline. A commit handshake swaps shadow into active atomically, after in-flight results drain. It sits between the configuration register file and any crossbar or bus-error logic that needs a reprogrammable slave index.

---
 rtl/addr_map_lookup_ctrl.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/addr_map_lookup_ctrl.sv
// Runtime-programmable address-map controller with a double-buffered rule table.
// The shadow bank takes configuration writes. The active bank serves lookups
// through a one-deep registered valid/ready stage. A commit swaps shadow into
// active once in-flight results have drained.

package addr_map_rule_pkg;
  typedef struct packed {
    logic [31:0] idx;
    logic [31:0] start_addr;
    logic [31:0] end_addr;
  } addr_map_rule_t;
endpackage

module addr_map_lookup_ctrl
  import addr_map_rule_pkg::*;
#(
  parameter int unsigned NUM_RULES   = 4,
  parameter logic [31:0] DEFAULT_IDX = 32'h0,
  parameter int unsigned SLOT_W      = (NUM_RULES > 1) ? $clog2(NUM_RULES) : 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              cfg_we_i,
  input  logic [SLOT_W-1:0] cfg_slot_i,
  input  addr_map_rule_t    cfg_rule_i,
  input  logic              cfg_en_i,
  input  logic              commit_req_i,
  output logic              commit_ack_o,
  output logic              busy_o,
  input  logic              lookup_valid_i,
  output logic              lookup_ready_o,
  input  logic [31:0]       lookup_addr_i,
  output logic              result_valid_o,
  input  logic              result_ready_i,
  output logic [31:0]       result_idx_o,
  output logic              result_hit_o,
  output logic              result_multi_o
);

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    SWAP
  } state_t;

  state_t state_q, state_d;

  addr_map_rule_t       sh_rule  [NUM_RULES];
  logic [NUM_RULES-1:0] sh_en;
  addr_map_rule_t       act_rule [NUM_RULES];
  logic [NUM_RULES-1:0] act_en;

  logic        match_hit;
  logic        match_multi;
  logic [31:0] match_idx;
  logic        lookup_accept;

  assign lookup_accept = lookup_valid_i && lookup_ready_o;

  // Shadow bank: written in any state. Slot numbers beyond NUM_RULES match no entry and are dropped.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < NUM_RULES; i++) begin
        sh_rule[i] <= '0;
      end
      sh_en <= '0;
    end else if (cfg_we_i) begin
      for (int unsigned i = 0; i < NUM_RULES; i++) begin
        if (cfg_slot_i == SLOT_W'(i)) begin
          sh_rule[i] <= cfg_rule_i;
          sh_en[i]   <= cfg_en_i;
        end
      end
    end
  end

  // Active bank: copies the shadow as it stood before any same-cycle write.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < NUM_RULES; i++) begin
        act_rule[i] <= '0;
      end
      act_en <= '0;
    end else if (state_q == SWAP) begin
      act_rule <= sh_rule;
      act_en   <= sh_en;
    end
  end

  // Decode the lookup address against the active bank. The lowest matching slot wins, and any further match flags an overlap.
  always_comb begin
    match_hit   = 1'b0;
    match_multi = 1'b0;
    match_idx   = DEFAULT_IDX;
    for (int unsigned i = 0; i < NUM_RULES; i++) begin
      if (act_en[i] &&
          (lookup_addr_i >= act_rule[i].start_addr) &&
          (lookup_addr_i <  act_rule[i].end_addr)) begin
        if (!match_hit) begin
          match_idx = act_rule[i].idx;
        end else begin
          match_multi = 1'b1;
        end
        match_hit = 1'b1;
      end
    end
  end

  // Result register: loads on accept, clears on consume, and holds while stalled.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      result_valid_o <= 1'b0;
      result_idx_o   <= '0;
      result_hit_o   <= 1'b0;
      result_multi_o <= 1'b0;
    end else if (lookup_accept) begin
      result_valid_o <= 1'b1;
      result_idx_o   <= match_idx;
      result_hit_o   <= match_hit;
      result_multi_o <= match_multi;
    end else if (result_ready_i) begin
      result_valid_o <= 1'b0;
    end
  end

  // Commit FSM state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Commit FSM next state. Requests seen outside IDLE are dropped.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (commit_req_i) state_d = DRAIN;
      DRAIN:   if (!result_valid_o || result_ready_i) state_d = SWAP;
      SWAP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs: ack and busy decode the registered state only. Ready also follows result_ready_i, so streaming runs without bubbles.
  always_comb begin
    commit_ack_o   = (state_q == SWAP);
    busy_o         = (state_q != IDLE);
    lookup_ready_o = (state_q == IDLE) && (!result_valid_o || result_ready_i);
  end

endmodule
